// File: rtl/serial_bus_pkg.sv
// Shared types for the serial bus arbiter and the master port logic.
//   arb_state_t : arbiter FSM states
//   instr_t     : serial bus instruction encodings used by the master ports
package serial_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic [2:0] {
        INSTR_NOP         = 3'b000,
        INSTR_READ        = 3'b001,
        INSTR_WRITE       = 3'b010,
        INSTR_BURST_READ  = 3'b011,
        INSTR_BURST_WRITE = 3'b100
    } instr_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
//   req      : request vector
//   ptr      : index of the last winner; search starts at ptr+1 (mod N)
//   winner_c : index of the first set request after ptr
//   valid_c  : any request present
module rr_picker #(
    parameter int unsigned N = 2,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner_c,
    output logic             valid_c
);

    // Walk distances from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        winner_c = '0;
        valid_c  = 1'b0;
        for (int unsigned d = N; d >= 1; d--) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (req[k] && (k == ((32'(ptr) + d) % N))) begin
                    winner_c = IDX_W'(k);
                    valid_c  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for the shared serial bus.
//   clk, rst     : clock, asynchronous active-high reset
//   m_req        : per-master level request, held for the whole transaction
//   m_done       : per-master transaction-complete pulse
//   m_slave_id   : packed slave id per master (master i at [i*SLAVE_ID_W +: SLAVE_ID_W])
//   m_grant      : one-hot grant
//   m_sel        : bus mux select (granted master index)
//   s_sel        : one-hot slave select
//   bus_busy     : a grant is active
//   timeout_err  : pulse when the watchdog reclaims the bus
//   addr_err     : pulse when the winner addressed a nonexistent slave
// Every output register is loaded from the decision made in the current state,
// so outputs show the effect of a state one cycle after that state is entered.
module serial_bus_arbiter
    import serial_bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned NUM_SLAVES  = 3,
    parameter int unsigned SLAVE_ID_W  = 2,
    parameter int unsigned TIMEOUT     = 1023,
    localparam int unsigned MASTER_ID_W = $clog2(NUM_MASTERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_done,
    input  logic [NUM_MASTERS*SLAVE_ID_W-1:0] m_slave_id,
    output logic [NUM_MASTERS-1:0]            m_grant,
    output logic [MASTER_ID_W-1:0]            m_sel,
    output logic [NUM_SLAVES-1:0]             s_sel,
    output logic                              bus_busy,
    output logic                              timeout_err,
    output logic                              addr_err
);

    localparam int unsigned WDOG_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned WDOG_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    arb_state_t                state_q, state_d;
    logic [MASTER_ID_W-1:0]    winner_q, winner_d;
    logic [SLAVE_ID_W-1:0]     id_q, id_d;
    logic [MASTER_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WDOG_W-1:0]         wdog_q, wdog_d;
    logic [NUM_MASTERS-1:0]    m_grant_q, m_grant_d;
    logic [MASTER_ID_W-1:0]    m_sel_q, m_sel_d;
    logic [NUM_SLAVES-1:0]     s_sel_q, s_sel_d;
    logic                      bus_busy_q, bus_busy_d;
    logic                      timeout_err_q, timeout_err_d;
    logic                      addr_err_q, addr_err_d;

    logic [MASTER_ID_W-1:0]    pick_idx_c;
    logic                      pick_valid_c;
    logic [NUM_MASTERS-1:0]    win_mask_c;
    logic                      win_done_c;
    logic                      win_req_c;

    rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req      (m_req),
        .ptr      (rr_ptr_q),
        .winner_c (pick_idx_c),
        .valid_c  (pick_valid_c)
    );

    // One-hot of the latched winner; done/req from other masters are masked off.
    always_comb begin
        win_mask_c = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            win_mask_c[i] = (32'(winner_q) == i);
        end
        win_done_c = |(m_done & win_mask_c);
        win_req_c  = |(m_req & win_mask_c);
    end

    // Next-state and output decisions.
    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        id_d          = id_q;
        rr_ptr_d      = rr_ptr_q;
        wdog_d        = wdog_q;
        m_grant_d     = m_grant_q;
        m_sel_d       = m_sel_q;
        s_sel_d       = s_sel_q;
        bus_busy_d    = bus_busy_q;
        timeout_err_d = 1'b0;
        addr_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                m_grant_d  = '0;
                s_sel_d    = '0;
                bus_busy_d = 1'b0;
                if (pick_valid_c) begin
                    winner_d = pick_idx_c;
                    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                        if (32'(pick_idx_c) == i) begin
                            id_d = m_slave_id[i*SLAVE_ID_W +: SLAVE_ID_W];
                        end
                    end
                    state_d = GRANT;
                end
            end
            GRANT: begin
                m_grant_d  = win_mask_c;
                m_sel_d    = winner_q;
                bus_busy_d = 1'b1;
                rr_ptr_d   = winner_q;
                wdog_d     = '0;
                s_sel_d    = '0;
                if (32'(id_q) < NUM_SLAVES) begin
                    for (int unsigned j = 0; j < NUM_SLAVES; j++) begin
                        s_sel_d[j] = (32'(id_q) == j);
                    end
                    state_d = BUSY;
                end else begin
                    addr_err_d = 1'b1;
                    state_d    = RELEASE;
                end
            end
            BUSY: begin
                // Done and abort take precedence over a coincident timeout.
                if (win_done_c || !win_req_c) begin
                    state_d = RELEASE;
                end else if ((TIMEOUT != 0) && (32'(wdog_q) == WDOG_LAST)) begin
                    timeout_err_d = 1'b1;
                    state_d       = RELEASE;
                end else if (wdog_q != {WDOG_W{1'b1}}) begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            RELEASE: begin
                m_grant_d  = '0;
                s_sel_d    = '0;
                bus_busy_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            winner_q      <= '0;
            id_q          <= '0;
            rr_ptr_q      <= MASTER_ID_W'(NUM_MASTERS - 1);
            wdog_q        <= '0;
            m_grant_q     <= '0;
            m_sel_q       <= '0;
            s_sel_q       <= '0;
            bus_busy_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            id_q          <= id_d;
            rr_ptr_q      <= rr_ptr_d;
            wdog_q        <= wdog_d;
            m_grant_q     <= m_grant_d;
            m_sel_q       <= m_sel_d;
            s_sel_q       <= s_sel_d;
            bus_busy_q    <= bus_busy_d;
            timeout_err_q <= timeout_err_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign m_grant     = m_grant_q;
    assign m_sel       = m_sel_q;
    assign s_sel       = s_sel_q;
    assign bus_busy    = bus_busy_q;
    assign timeout_err = timeout_err_q;
    assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: 2 masters, 3 slaves, TIMEOUT=8.
module tb_serial_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] m_req;
    logic [1:0] m_done;
    logic [3:0] m_slave_id;
    logic [1:0] m_grant;
    logic       m_sel;
    logic [2:0] s_sel;
    logic       bus_busy;
    logic       timeout_err;
    logic       addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    serial_bus_arbiter #(
        .NUM_MASTERS (2),
        .NUM_SLAVES  (3),
        .SLAVE_ID_W  (2),
        .TIMEOUT     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req       (m_req),
        .m_done      (m_done),
        .m_slave_id  (m_slave_id),
        .m_grant     (m_grant),
        .m_sel       (m_sel),
        .s_sel       (s_sel),
        .bus_busy    (bus_busy),
        .timeout_err (timeout_err),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] g, input logic ms,
                            input logic [2:0] ss, input logic b, input logic te,
                            input logic ae);
        chk({tag, ".m_grant"},     32'(m_grant),     32'(g));
        chk({tag, ".m_sel"},       32'(m_sel),       32'(ms));
        chk({tag, ".s_sel"},       32'(s_sel),       32'(ss));
        chk({tag, ".bus_busy"},    32'(bus_busy),    32'(b));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(te));
        chk({tag, ".addr_err"},    32'(addr_err),    32'(ae));
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        m_req      = 2'b00;
        m_done     = 2'b00;
        m_slave_id = 4'b0000;

        // Reset state
        tick();
        tick();
        chk_outs("reset", 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_outs("idle", 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        // Single request: master 0 to slave 1
        m_req      = 2'b01;
        m_slave_id = 4'b0001;
        tick();
        chk("single.grant_latency", 32'(m_grant), 32'd0);
        tick();
        chk_outs("single.granted", 2'b01, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single.held", 32'(m_grant), 32'd1);
        end
        m_done = 2'b01;
        tick();
        m_done = 2'b00;
        m_req  = 2'b00;
        chk_outs("single.done_edge", 2'b01, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
        tick();
        chk_outs("single.release", 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        // Contention from a fresh reset: order 0,1,0,1 with two empty cycles between
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        m_req      = 2'b11;
        m_slave_id = 4'b1000;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("contend.gap_grant", 32'(m_grant), 32'd0);
            tick();
            if (g % 2 == 0) chk_outs("contend.win0", 2'b01, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
            else            chk_outs("contend.win1", 2'b10, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                tick();
                chk("contend.held", 32'(m_grant), (g % 2 == 0) ? 32'd1 : 32'd2);
            end
            m_done = (g % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            m_done = 2'b00;
            tick();
            chk("contend.gap_idle", 32'(m_grant), 32'd0);
            chk("contend.gap_busy", 32'(bus_busy), 32'd0);
        end
        m_req = 2'b00;
        tick();

        // Abort: master 1 drops its request mid-transaction
        m_req      = 2'b10;
        m_slave_id = 4'b0100;
        tick();
        tick();
        chk_outs("abort.granted", 2'b10, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        m_req = 2'b00;
        tick();
        chk_outs("abort.edge", 2'b10, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        tick();
        chk_outs("abort.release", 2'b00, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0);

        // Watchdog: master 0 stalls, master 1 pending
        m_req      = 2'b11;
        m_slave_id = 4'b0100;
        tick();
        tick();
        chk_outs("wdog.granted", 2'b01, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("wdog.no_err_yet", 32'(timeout_err), 32'd0);
        end
        tick();
        chk_outs("wdog.fire", 2'b01, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0);
        tick();
        chk_outs("wdog.release", 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("wdog.gap", 32'(m_grant), 32'd0);
        tick();
        chk_outs("wdog.next_m1", 2'b10, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        m_done = 2'b10;
        m_req  = 2'b00;
        tick();
        m_done = 2'b00;
        tick();

        // Bad slave id: addr_err pulse, one-cycle grant, no slave selected
        m_req      = 2'b01;
        m_slave_id = 4'b0011;
        tick();
        tick();
        m_req = 2'b00;
        chk_outs("addr.err", 2'b01, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        chk_outs("addr.release", 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        // Done on the timeout cycle: no timeout_err
        m_req      = 2'b01;
        m_slave_id = 4'b0010;
        tick();
        tick();
        chk_outs("coinc.granted", 2'b01, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) tick();
        m_done = 2'b01;
        tick();
        m_done = 2'b00;
        m_req  = 2'b00;
        chk_outs("coinc.done", 2'b01, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
        tick();
        chk_outs("coinc.release", 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);

        // Async reset mid-BUSY while master 0 holds the bus
        m_req      = 2'b01;
        m_slave_id = 4'b0001;
        tick();
        tick();
        chk_outs("areset.granted", 2'b01, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_outs("areset.immediate", 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        rst   = 1'b0;
        m_req = 2'b11;
        tick();
        tick();
        chk_outs("areset.m0_first", 2'b01, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
        m_req = 2'b00;
        tick();
        tick();
        chk("areset.release", 32'(m_grant), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_bus_arbiter.md
Name: serial_bus_arbiter

Overview:
- Shares the single serial bus between NUM_MASTERS master ports (each an in-port/out-port pair) using round-robin arbitration.
- Latches the winning master's slave id, drives the bus mux select and a one-hot slave select, and holds the grant until the master signals transaction done.
- Watchdog timeout reclaims the bus from a stalled master.
- Sits between the master cores' port logic and the bus interconnect mux.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- NUM_SLAVES, 3, number of slaves on the bus (2..8)
- SLAVE_ID_W, 2, width of each master's slave id field; ≥ clog2(NUM_SLAVES)
- TIMEOUT, 1023, max cycles a grant may be held in BUSY; 0 disables the watchdog
- MASTER_ID_W, clog2(NUM_MASTERS), derived; not overridable

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m_req  in  NUM_MASTERS  per-master bus request, level, held for the whole transaction
- m_done  in  NUM_MASTERS  per-master transaction-complete pulse (rx_done/tx_done of that master's ports)
- m_slave_id  in  NUM_MASTERS*SLAVE_ID_W  packed slave id per master; master i occupies bits [i*SLAVE_ID_W +: SLAVE_ID_W]
- m_grant  out  NUM_MASTERS  one-hot grant, at most one bit set
- m_sel  out  MASTER_ID_W  bus mux select = index of granted master
- s_sel  out  NUM_SLAVES  one-hot slave select for the latched slave id
- bus_busy  out  1  high while any grant is active
- timeout_err  out  1  one-cycle pulse when the watchdog reclaims the bus
- addr_err  out  1  one-cycle pulse when the winner requested slave id ≥ NUM_SLAVES

Behaviour:
- Reset values: m_grant=0, m_sel=0, s_sel=0, bus_busy=0, timeout_err=0, addr_err=0, state=IDLE, rr_ptr=NUM_MASTERS-1 (so master 0 wins first), wdog=0. All outputs are registered.
- IDLE:
  - If any m_req is set, pick the winner by round-robin: search from rr_ptr+1 modulo NUM_MASTERS; the first set bit wins.
  - Latch winner index and its m_slave_id; go to GRANT.
  - With no request, stay in IDLE.
- GRANT (1 cycle):
  - Assert m_grant[winner], m_sel=winner, bus_busy=1, rr_ptr<=winner, wdog<=0.
  - If latched id < NUM_SLAVES: s_sel[id]=1, go to BUSY.
  - Otherwise: s_sel=0, pulse addr_err, go to RELEASE.
  - Latency: request sampled in IDLE at edge N, m_grant visible after edge N+1.
- BUSY:
  - Grant held; wdog increments each cycle.
  - Exit to RELEASE on the first of:
    - m_done[winner]=1 (normal)
    - m_req[winner]=0 (abort, no error)
    - TIMEOUT≠0 and wdog==TIMEOUT-1 (pulse timeout_err)
  - m_done from non-granted masters is ignored.
  - If done and timeout occur in the same cycle, done wins and timeout_err stays 0.
- RELEASE (1 cycle turnaround):
  - m_grant=0, s_sel=0, bus_busy=0; go to IDLE.
  - Requests are not sampled in RELEASE.
  - Minimum gap between consecutive grants is 2 cycles (RELEASE + IDLE).
- Fairness:
  - With all masters requesting continuously, grants rotate 0,1,..,N-1,0.
  - A master that keeps m_req high after done is re-eligible only after the others have had their turn.
- m_slave_id changes after GRANT are ignored until the next arbitration.
- Reset mid-transaction: all outputs drop to their reset values immediately (asynchronous); round-robin history is lost.
- Watchdog counter width is clog2(TIMEOUT+1), saturating; it never wraps within BUSY.

Decomposition:
- Shared package serial_bus_pkg:
  - state typedef arb_state_t {IDLE, GRANT, BUSY, RELEASE}
  - instruction encodings (read 3'b001, burst read 3'b011, etc.) shared with the master ports
- One sub-module rr_picker: combinational round-robin priority encoder; inputs req vector and rr_ptr; outputs winner index and valid. Reusable for a future slave-side arbiter.

Test Plan:
- Single request: reset, m_req=2'b01, slave id 1, m_done pulse at cycle 20 → m_grant=01 one cycle after the request, s_sel=3'b010, bus_busy=1 until done, then one RELEASE cycle with all outputs 0.
- Contention: m_req=2'b11 held, each master completes after 5 busy cycles → grant order 0,1,0,1 with exactly 2 idle cycles between grants.
- Abort: master 1 granted, drops m_req in BUSY at cycle 3 → grant released next edge, timeout_err=0, addr_err=0.
- Watchdog: TIMEOUT=8, master 0 granted, never sends done → timeout_err pulses once exactly 8 cycles after entering BUSY, then the bus is released and the pending master 1 is granted.
- Edge cases: slave id 3 with NUM_SLAVES=3 → addr_err pulse, s_sel=0, grant lasts 1 cycle. Done coinciding with the timeout cycle → no timeout_err.
- Async reset: rst asserted mid-BUSY → m_grant, s_sel, bus_busy go to 0 without waiting for a clock edge; after release, master 0 wins first.
